aes_beat_ctrl: RTL and testbench
================================

// Module: aes_beat_ctrl
// PURPOSE
//   Parametrised I/O sequencer for the AES-128 engine. Loads a 128-bit block and key in BUS_W-bit beats,
//   starts the external round core in encrypt or decrypt mode, then returns result and final round key
//   in beats over a valid/ready stream. Adds back-pressure, key reuse and core timeout detection.
// PARAMETERS
//   BUS_W      64    beat width; legal values 32, 64, 128; BEATS = 128/BUS_W
//   TIMEOUT    31    max cycles from core_start to core_done before error; range 1..1023
// PORTS
//   CLK          in   1      clock, all logic on rising edge
//   reset        in   1      synchronous, active-high reset
//   Start        in   1      request pulse; honoured only in IDLE
//   Select       in   1      mode: 0 = encrypt, 1 = decrypt; sampled with Start
//   key_keep     in   1      1 = reuse stored key, skip key beats; sampled with Start
//   in_valid     in   1      input beat valid
//   in_ready     out  1      input beat accepted when in_valid & in_ready
//   DATA         in   BUS_W  block beat, most-significant beat first
//   KEY          in   BUS_W  key beat, same order as DATA; ignored when key_keep latched
//   out_valid    out  1      output beat valid
//   out_ready    in   1      output beat consumed when out_valid & out_ready
//   Cipher_text  out  BUS_W  result beat, most-significant first
//   KEY10        out  BUS_W  final round key beat, aligned with Cipher_text
//   busy         out  1      high in LOAD, RUN, UNLOAD
//   done         out  1      one-cycle pulse after last output beat accepted
//   error        out  1      sticky timeout flag; cleared by reset or next accepted Start
//   core_start   out  1      one-cycle pulse to round core
//   core_mode    out  1      latched Select
//   core_block   out  128    assembled block register
//   core_key     out  128    key register
//   core_done    in   1      round core completion pulse
//   core_result  in   128    core output, valid with core_done
//   core_key_last in  128    final round key, valid with core_done
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; beat counter, timeout counter, block/key/result registers 0.
//   FSM IDLE -> LOAD -> RUN -> UNLOAD -> IDLE.
//   IDLE: Start=1 latches Select, key_keep, clears error, beat count = 0, -> LOAD next cycle.
//   LOAD: in_ready=1. Each accepted beat shifts DATA in at LSB end (block <= {block, DATA});
//     KEY shifted likewise unless key_keep latched. After BEATS-th beat -> RUN; in_ready drops
//     the cycle after the last beat. BUS_W=128: single beat.
//   RUN: core_start=1 on first RUN cycle only. core_done sampled from the following cycle;
//     core_done coincident with core_start ignored. On core_done capture core_result, core_key_last
//     -> UNLOAD. Timeout counter increments each RUN cycle after core_start; reaching TIMEOUT
//     without core_done sets error, -> IDLE, no output beats, done stays 0.
//   UNLOAD: out_valid=1; Cipher_text/KEY10 = top BUS_W bits of shift registers; on accept shift
//     left by BUS_W. out_valid/data hold stable while out_ready=0. Last beat accepted -> IDLE,
//     done=1 for that following cycle (out_valid=0 same cycle).
//   Start outside IDLE ignored (no effect on latched mode). in_valid outside LOAD ignored.
//   key_keep with no prior loaded key uses reset value 0.
//   reset mid-operation: immediate return to IDLE, partial beats discarded, stored key cleared.
//   Latency (no stalls): Start -> first in_ready 1 cycle; last input beat -> core_start 1 cycle;
//     core_done -> first out_valid 1 cycle.
// TESTING
//   BUS_W=64, key 000102..0f, pt 00112233..ff, Select=0, model core -> Cipher_text beats
//     69c4e0d86a7b0430, d8cdb78070b4c55a; done one cycle after 2nd accept.
//   Same with Select=1, block 69c4..c55a, key_keep=1 -> beats 0011223344556677, 8899aabbccddeeff;
//     only 2 DATA beats taken, KEY bus driven X ignored.
//   BUS_W=32, in_valid toggled 1/0 and out_ready held low 5 cycles -> 4 beats each way, outputs stable
//     while stalled, result identical to case 1.
//   Core never asserts done, TIMEOUT=31 -> error=1 at 31st RUN cycle after core_start, IDLE, no out_valid.
//   reset asserted after 1 of 2 input beats -> next cycle all outputs 0; fresh Start completes normally.
//   Start pulsed during RUN and UNLOAD -> ignored; core_start count stays 1 per transaction.

Source files
------------

// File: rtl/aes_beat_ctrl.sv
// -----------------------------------------------------------------------------
// aes_beat_ctrl
//   I/O sequencer for an external AES-128 round core. A 128-bit block and key
//   arrive in BUS_W-bit beats (most-significant beat first). The core is then
//   started in encrypt or decrypt mode. Its result and final round key are
//   returned in beats over a valid/ready stream. The block supports
//   back-pressure on both streams, reuse of the previously loaded key, and a
//   sticky error flag when the core does not answer in time.
//
// Parameters
//   BUS_W    beat width: 32, 64 or 128 (BEATS = 128 / BUS_W)
//   TIMEOUT  number of cycles after core_start the core may take (1..1023)
//
// Ports
//   CLK, reset            clock; synchronous active-high reset
//   Start, Select         request pulse (IDLE only); 0 = encrypt, 1 = decrypt
//   key_keep              reuse the stored key and skip the key beats
//   in_valid/in_ready     input beat handshake for DATA and KEY
//   out_valid/out_ready   output beat handshake for Cipher_text and KEY10
//   busy, done, error     status: active, end-of-job pulse, sticky timeout
//   core_start/core_mode  start pulse and latched mode to the round core
//   core_block/core_key   assembled block and key registers
//   core_done, core_result, core_key_last   core completion and its outputs
// -----------------------------------------------------------------------------
module aes_beat_ctrl #(
  parameter int BUS_W   = 64,
  parameter int TIMEOUT = 31
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Start,
  input  logic             Select,
  input  logic             key_keep,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] DATA,
  input  logic [BUS_W-1:0] KEY,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] Cipher_text,
  output logic [BUS_W-1:0] KEY10,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             core_start,
  output logic             core_mode,
  output logic [127:0]     core_block,
  output logic [127:0]     core_key,
  input  logic             core_done,
  input  logic [127:0]     core_result,
  input  logic [127:0]     core_key_last
);

  localparam int         BEATS     = 128 / BUS_W;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
  localparam logic [9:0] TO_LAST   = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_UNLOAD
  } state_t;

  state_t       state;
  logic [2:0]   beat_cnt;
  logic [9:0]   to_cnt;
  logic         keep_q;
  logic [127:0] res_sr;
  logic [127:0] kl_sr;

  logic in_fire;
  logic out_fire;

  // in_ready is only ever high in LOAD and out_valid only in UNLOAD, so the
  // handshakes need no extra state qualification.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Output beats are always the top slice of the result shift registers.
  assign Cipher_text = res_sr[127 -: BUS_W];
  assign KEY10       = kl_sr[127 -: BUS_W];

  // NOTE: non-blocking assignments throughout, so every branch below reads
  // the pre-edge value of each register (e.g. core_start in the first RUN cycle).
  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: the wide data registers are reset as well: reset must discard a
      // partial load and clear the stored key that key_keep would reuse.
      state      <= S_IDLE;
      beat_cnt   <= '0;
      to_cnt     <= '0;
      keep_q     <= 1'b0;
      res_sr     <= '0;
      kl_sr      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_start <= 1'b0;
      core_mode  <= 1'b0;
      core_block <= '0;
      core_key   <= '0;
    end else begin
      done       <= 1'b0;
      core_start <= 1'b0;

      case (state)
        S_IDLE: begin
          if (Start) begin
            core_mode <= Select;
            keep_q    <= key_keep;
            error     <= 1'b0;
            beat_cnt  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (in_fire) begin
            // Beats arrive MSB first, so each new beat enters at the LSB end.
            core_block <= (core_block << BUS_W) | 128'(DATA);
            if (!keep_q) begin
              core_key <= (core_key << BUS_W) | 128'(KEY);
            end
            if (beat_cnt == LAST_BEAT) begin
              in_ready   <= 1'b0;
              core_start <= 1'b1;
              to_cnt     <= '0;
              state      <= S_RUN;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end

        S_RUN: begin
          if (core_start) begin
            // First RUN cycle: a core_done seen alongside core_start belongs
            // to no request of ours and is dropped.
          end else if (core_done) begin
            res_sr    <= core_result;
            kl_sr     <= core_key_last;
            beat_cnt  <= '0;
            out_valid <= 1'b1;
            state     <= S_UNLOAD;
          end else if (to_cnt == TO_LAST) begin
            // TIMEOUT waiting cycles have elapsed with no answer.
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 10'd1;
          end
        end

        S_UNLOAD: begin
          if (out_fire) begin
            res_sr <= res_sr << BUS_W;
            kl_sr  <= kl_sr << BUS_W;
            if (beat_cnt == LAST_BEAT) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_beat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_beat_ctrl
//   Two sequencers share one clock and reset: index 0 uses BUS_W=64 and
//   index 1 uses BUS_W=32. Each has a behavioural round-core stand-in. The
//   stand-in answers with the FIPS-197 vector when it sees that vector's
//   operands, and with a fixed scramble of its operands otherwise. Expected
//   beats are slices of that function applied to the operands the bench sent.
// -----------------------------------------------------------------------------
module tb_aes_beat_ctrl;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  logic         start [2], sel [2], keep [2], in_valid [2], out_ready [2];
  logic         in_ready [2], out_valid [2], busy [2], done [2], error [2];
  logic         core_start [2], core_mode [2], core_done [2];
  logic [127:0] core_block [2], core_key [2], core_result [2], core_key_last [2];
  logic [63:0]  data64, key64, ct64, k10_64;
  logic [31:0]  data32, key32, ct32, k10_32;
  logic [63:0]  ct_bus [2], k10_bus [2];

  assign ct_bus[0]  = ct64;
  assign ct_bus[1]  = {32'b0, ct32};
  assign k10_bus[0] = k10_64;
  assign k10_bus[1] = {32'b0, k10_32};

  aes_beat_ctrl #(.BUS_W(64), .TIMEOUT(31)) dut (
    .CLK(CLK), .reset(reset), .Start(start[0]), .Select(sel[0]), .key_keep(keep[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .DATA(data64), .KEY(key64),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .Cipher_text(ct64), .KEY10(k10_64),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .core_start(core_start[0]),
    .core_mode(core_mode[0]), .core_block(core_block[0]), .core_key(core_key[0]),
    .core_done(core_done[0]), .core_result(core_result[0]), .core_key_last(core_key_last[0])
  );

  aes_beat_ctrl #(.BUS_W(32), .TIMEOUT(31)) dut32 (
    .CLK(CLK), .reset(reset), .Start(start[1]), .Select(sel[1]), .key_keep(keep[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .DATA(data32), .KEY(key32),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .Cipher_text(ct32), .KEY10(k10_32),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .core_start(core_start[1]),
    .core_mode(core_mode[1]), .core_block(core_block[1]), .core_key(core_key[1]),
    .core_done(core_done[1]), .core_result(core_result[1]), .core_key_last(core_key_last[1])
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the key each sequencer should hold for key_keep.
  logic [127:0] stored_key [2];

  // Core stand-in controls and observations.
  int           core_lat [2];
  bit           core_hang [2], core_glitch [2];
  int           starts [2];
  int           cnt_m [2];
  logic [127:0] res_m [2], kl_m [2], cap_block [2], cap_key [2];
  logic         cap_mode [2];

  function automatic logic [127:0] core_res_fn(input logic [127:0] b, input logic [127:0] k,
                                               input logic m);
    if (!m && b == PT && k == K0) return CT;
    if (m && b == CT && k == K0) return PT;
    return m ? ({b[63:0], b[127:64]} ^ k) : (b ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969);
  endfunction

  function automatic logic [127:0] core_kl_fn(input logic [127:0] k);
    return (k == K0) ? K10 : ~{k[95:0], k[127:96]};
  endfunction

  // Beat b (MSB first) of a 128-bit word, right-aligned in 64 bits.
  function automatic logic [63:0] beat_of(input logic [127:0] v, input int b, input int bw);
    logic [127:0] t;
    t = (v << (b * bw)) >> (128 - bw);
    return t[63:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-core stand-in. A pulse of core_done in the core_start cycle itself
  // (glitch) carries junk that the sequencer must not capture.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      core_done[i] = 1'b0;
      if (reset === 1'b1) begin
        cnt_m[i] = 0;
      end else begin
        if (cnt_m[i] > 0) begin
          cnt_m[i]--;
          if (cnt_m[i] == 0) begin
            core_done[i]     = 1'b1;
            core_result[i]   = res_m[i];
            core_key_last[i] = kl_m[i];
          end
        end
        if (core_start[i] === 1'b1) begin
          starts[i]++;
          cap_block[i] = core_block[i];
          cap_key[i]   = core_key[i];
          cap_mode[i]  = core_mode[i];
          res_m[i]     = core_res_fn(core_block[i], core_key[i], core_mode[i]);
          kl_m[i]      = core_kl_fn(core_key[i]);
          cnt_m[i]     = core_hang[i] ? 0 : core_lat[i];
          if (core_glitch[i]) begin
            core_done[i]     = 1'b1;
            core_result[i]   = ~res_m[i];
            core_key_last[i] = ~kl_m[i];
          end
        end
      end
    end
  end

  task automatic drive_beat(input int i, input logic [63:0] d, input logic [63:0] k, input logic v);
    in_valid[i] = v;
    if (i == 0) begin
      data64 = d;
      key64  = k;
    end else begin
      data32 = d[31:0];
      key32  = k[31:0];
    end
  endtask

  // Called at a negedge with the sequencer idle.
  task automatic begin_txn(input int i, input string name, input logic mode, input logic kk);
    start[i] = 1'b1;
    sel[i]   = mode;
    keep[i]  = kk;
    @(negedge CLK);
    start[i] = 1'b0;
    sel[i]   = ~mode;
    keep[i]  = ~kk;
    vectors++;
    if ({in_ready[i], busy[i], error[i]} !== 3'b110) begin
      miscompares++;
      $display("FAIL %s start->load: in_ready/busy/error got %b%b%b want 110", name, in_ready[i], busy[i], error[i]);
    end
  endtask

  task automatic load_beats(input int i, input string name, input logic [127:0] blk,
                            input logic [127:0] kin, input logic kk, input int in_gap);
    int bw, g;
    bw = (i == 0) ? 64 : 32;
    for (int b = 0; b < 128 / bw; b++) begin
      g = (in_gap < 0) ? int'($urandom_range(0, 2)) : in_gap;
      repeat (g) begin
        drive_beat(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        @(negedge CLK);
      end
      drive_beat(i, beat_of(blk, b, bw), kk ? 64'bx : beat_of(kin, b, bw), 1'b1);
      vectors++;
      if (in_ready[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL %s load beat %0d: in_ready got %b want 1", name, b, in_ready[i]);
      end
      @(negedge CLK);
    end
    drive_beat(i, '0, '0, 1'b0);
  endtask

  task automatic run_txn(input int i, input string name, input logic [127:0] blk, input logic [127:0] kin,
                         input logic mode, input logic kk, input int lat, input int in_gap,
                         input int out_stall, input bit glitch, input bit poke);
    int bw, g, waited, st0;
    logic [127:0] ekey, eres, ekl;
    logic [63:0] eb, ek;
    bw   = (i == 0) ? 64 : 32;
    ekey = kk ? stored_key[i] : kin;
    eres = core_res_fn(blk, ekey, mode);
    ekl  = core_kl_fn(ekey);
    core_lat[i]    = lat;
    core_glitch[i] = glitch;
    core_hang[i]   = 1'b0;
    st0 = starts[i];

    begin_txn(i, name, mode, kk);
    load_beats(i, name, blk, kin, kk, in_gap);
    stored_key[i] = ekey;
    vectors++;
    if (core_start[i] !== 1'b1 || in_ready[i] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s last beat->core_start: core_start %b in_ready %b want 1 0", name, core_start[i], in_ready[i]);
    end

    if (poke) begin
      start[i] = 1'b1;
      sel[i]   = ~mode;
      keep[i]  = ~kk;
      drive_beat(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    end
    waited = 0;
    while (out_valid[i] !== 1'b1 && waited < lat + 4) begin
      @(negedge CLK);
      waited++;
    end
    vectors++;
    if (waited != lat + 1) begin
      miscompares++;
      $display("FAIL %s core_start->out_valid cycles got %0d want %0d", name, waited, lat + 1);
    end
    vectors++;
    if (cap_block[i] !== blk || cap_key[i] !== ekey || cap_mode[i] !== mode) begin
      miscompares++;
      $display("FAIL %s core operands got %h %h %b want %h %h %b", name, cap_block[i], cap_key[i], cap_mode[i], blk, ekey, mode);
    end

    for (int b = 0; b < 128 / bw; b++) begin
      eb = beat_of(eres, b, bw);
      ek = beat_of(ekl, b, bw);
      g  = (out_stall < 0) ? int'($urandom_range(0, 2)) : ((b == 0) ? out_stall : 0);
      for (int s = 0; s < g; s++) begin
        out_ready[i] = 1'b0;
        vectors++;
        if (out_valid[i] !== 1'b1 || ct_bus[i] !== eb || k10_bus[i] !== ek) begin
          miscompares++;
          $display("FAIL %s stall beat %0d cyc %0d: valid %b ct %h k10 %h want 1 %h %h", name, b, s, out_valid[i], ct_bus[i], k10_bus[i], eb, ek);
        end
        @(negedge CLK);
      end
      out_ready[i] = 1'b1;
      start[i]     = 1'b0;
      vectors++;
      if (out_valid[i] !== 1'b1 || ct_bus[i] !== eb || k10_bus[i] !== ek) begin
        miscompares++;
        $display("FAIL %s out beat %0d: valid %b ct %h k10 %h want 1 %h %h", name, b, out_valid[i], ct_bus[i], k10_bus[i], eb, ek);
      end
      @(negedge CLK);
    end
    out_ready[i] = 1'b0;
    drive_beat(i, '0, '0, 1'b0);
    vectors++;
    if ({out_valid[i], done[i], busy[i], core_mode[i]} !== {3'b010, mode}) begin
      miscompares++;
      $display("FAIL %s end: out_valid/done/busy/mode got %b%b%b%b want 010%b", name, out_valid[i], done[i], busy[i], core_mode[i], mode);
    end
    @(negedge CLK);
    vectors++;
    if (done[i] !== 1'b0 || starts[i] - st0 != 1) begin
      miscompares++;
      $display("FAIL %s after end: done %b core_start pulses %0d want 0 1", name, done[i], starts[i] - st0);
    end
    sel[i]  = 1'b0;
    keep[i] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; sel[i] = 1'b0; keep[i] = 1'b0;
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      core_lat[i] = 1; core_hang[i] = 1'b0; core_glitch[i] = 1'b0;
      stored_key[i] = '0;
    end
    data64 = '0; key64 = '0; data32 = '0; key32 = '0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({in_ready[i], out_valid[i], busy[i], done[i], error[i], core_start[i], core_mode[i]} !== 7'b0) begin
        miscompares++;
        $display("FAIL reset[%0d] flags got %b%b%b%b%b%b%b want 0", i, in_ready[i], out_valid[i], busy[i], done[i], error[i], core_start[i], core_mode[i]);
      end
      vectors++;
      if (core_block[i] !== '0 || core_key[i] !== '0) begin
        miscompares++;
        $display("FAIL reset[%0d] block/key got %h %h want 0", i, core_block[i], core_key[i]);
      end
      vectors++;
      if (ct_bus[i] !== '0 || k10_bus[i] !== '0) begin
        miscompares++;
        $display("FAIL reset[%0d] beats got %h %h want 0", i, ct_bus[i], k10_bus[i]);
      end
    end
  endtask

  task automatic test_known_vectors;
    run_txn(0, "enc64_fips", PT, K0, 1'b0, 1'b0, 3, 0, 0, 1'b0, 1'b0);
    run_txn(0, "dec64_keep", CT, 128'h0, 1'b1, 1'b1, 2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_32;
    run_txn(1, "stall32_fips", PT, K0, 1'b0, 1'b0, 2, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_core_timing;
    run_txn(0, "coincident_done", rand128(), rand128(), 1'b0, 1'b0, 1, 0, 0, 1'b1, 1'b0);
    run_txn(1, "coincident_done32", rand128(), rand128(), 1'b1, 1'b0, 4, 0, 0, 1'b1, 1'b0);
    run_txn(0, "done_at_limit", rand128(), rand128(), 1'b1, 1'b0, 31, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    logic [127:0] kin;
    kin = rand128();
    core_hang[0] = 1'b1;
    begin_txn(0, "timeout", 1'b0, 1'b0);
    load_beats(0, "timeout", rand128(), kin, 1'b0, 0);
    stored_key[0] = kin;
    vectors++;
    if (core_start[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout core_start got %b want 1", core_start[0]);
    end
    for (int j = 1; j <= 32; j++) begin
      @(negedge CLK);
      vectors++;
      if (out_valid[0] !== 1'b0 || error[0] !== (j == 32)) begin
        miscompares++;
        $display("FAIL timeout cycle %0d after core_start: out_valid %b error %b want 0 %b", j, out_valid[0], error[0], (j == 32));
      end
    end
    vectors++;
    if ({busy[0], done[0], in_ready[0]} !== 3'b000) begin
      miscompares++;
      $display("FAIL timeout idle: busy/done/in_ready got %b%b%b want 000", busy[0], done[0], in_ready[0]);
    end
    core_hang[0] = 1'b0;
    run_txn(0, "after_timeout", rand128(), rand128(), 1'b0, 1'b0, 2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    begin_txn(0, "reset_mid", 1'b1, 1'b0);
    drive_beat(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    @(negedge CLK);
    drive_beat(0, '0, '0, 1'b0);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    stored_key[0] = '0;
    stored_key[1] = '0;
    vectors++;
    if ({in_ready[0], out_valid[0], busy[0], done[0], error[0], core_start[0], core_mode[0]} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid flags got %b%b%b%b%b%b%b want 0", in_ready[0], out_valid[0], busy[0], done[0], error[0], core_start[0], core_mode[0]);
    end
    vectors++;
    if (core_block[0] !== '0 || core_key[0] !== '0 || ct_bus[0] !== '0 || k10_bus[0] !== '0) begin
      miscompares++;
      $display("FAIL reset_mid regs got %h %h %h %h want 0", core_block[0], core_key[0], ct_bus[0], k10_bus[0]);
    end
    // key_keep straight after reset must use the all-zero key.
    run_txn(0, "keep_after_reset", rand128(), rand128(), 1'b0, 1'b1, 2, -1, -1, 1'b0, 1'b0);
    run_txn(1, "keep_after_reset32", rand128(), rand128(), 1'b1, 1'b1, 3, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored;
    run_txn(0, "start_in_run_unload", rand128(), rand128(), 1'b0, 1'b0, 5, 0, 3, 1'b0, 1'b1);
    run_txn(1, "start_in_run_unload32", rand128(), rand128(), 1'b1, 1'b0, 3, 0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 16; n++) begin
      run_txn(int'($urandom_range(0, 1)), "random", rand128(), rand128(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
              -1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_stall_32();
    test_core_timing();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
